dmem_bus_ctrl: RTL and testbench
================================

// Module: dmem_bus_ctrl
// PURPOSE
//  Data-side bus controller between the core's load/store port and data memory/peripherals.
//  Replaces the direct core-to-RAM word wiring of the previous top level with a multi-cycle,
//  stalling access engine. Adds byte/half/word access with sign/zero extension and address
//  decode (RAM, IO window). Adds configurable RAM wait states, an IO ready handshake with timeout, and error reporting.
// PARAMETERS
//  RAM_WORDS   1024          RAM depth in 32-bit words (power of two)
//  RAM_WAIT    0             extra wait cycles per RAM access (0..15)
//  IO_BASE     32'h0001_0000 byte base address of IO window (aligned to IO_SPAN)
//  IO_SPAN     256           IO window size in bytes (power of two)
//  IO_TIMEOUT  15            max cycles waiting for io_ready before error (>=1)
// PORTS
//  CLK        in   1   clock, rising edge
//  RESET_N    in   1   asynchronous reset, active low
//  daddr      in   32  core byte address
//  ddata_w    in   32  core store data (value in LSBs)
//  MemRead    in   1   load request
//  MemWrite   in   1   store request
//  size       in   2   00 byte, 01 half, 10 word, 11 illegal
//  unsigned_n in   1   0 = zero-extend load, 1 = sign-extend load
//  ddata_r    out  32  load result, extended
//  stall      out  1   core must hold request stable while high
//  bus_err    out  1   one-cycle error pulse, coincident with completion
//  ram_addr   out  $clog2(RAM_WORDS)  RAM word address
//  ram_wdata  out  32  lane-replicated store data
//  ram_be     out  4   byte enables
//  ram_wren   out  1   RAM write strobe
//  ram_rden   out  1   RAM read strobe (rdata valid next cycle)
//  ram_rdata  in   32  RAM read data
//  io_addr    out  $clog2(IO_SPAN)  byte offset in IO window
//  io_wdata   out  32  lane-replicated store data
//  io_be      out  4   byte enables
//  io_wr/io_rd out 1   IO strobes, held until io_ready or timeout
//  io_ready   in   1   IO completes access this cycle
//  io_rdata   in   32  IO read data, valid with io_ready
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, except stall = MemRead|MemWrite (combinational from IDLE).
//  stall = (MemRead|MemWrite) & (state != DONE).
//  IDLE: on request, latch addr/data/size/sign and decode. Error cases (size 11; misaligned
//   half a[0]!=0 or word a[1:0]!=0; unmapped address; MemRead&MemWrite both high) -> DONE
//   with bus_err and no strobe issued. RAM hit (daddr < RAM_WORDS*4) -> ACCESS. IO hit -> IO_REQ.
//  ACCESS: ram_rden or ram_wren high exactly this cycle; counter <= RAM_WAIT; -> WAIT.
//  WAIT: first cycle captures ram_rdata; decrement counter; at 0 -> DONE.
//   RAM latency: stall high RAM_WAIT+3 cycles, then a DONE cycle with stall low.
//  IO_REQ: io_rd/io_wr held high; io_ready -> capture io_rdata, -> DONE.
//   IO_TIMEOUT cycles without io_ready -> drop strobes, bus_err, data 0, -> DONE.
//  DONE: ddata_r updated (registered, held until next DONE); bus_err pulses if flagged;
//   request still visible is ignored (it is the completing op); -> IDLE.
//  Lanes: be = byte 4'b0001<<a[1:0], half 4'b0011<<a[1:0], word 4'hF.
//   wdata = byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  Load: shift rdata right by 8*a[1:0], extend from bit 7/15 per unsigned_n; error -> 0.
//  Back-to-back ops: the next request is seen in the IDLE cycle after DONE; no dropped requests.
//  Reset mid-access: all strobes cleared immediately, no completion, no bus_err.
// TESTING
//  RAM_WAIT=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> stall 3 cycles each, ddata_r=0xDEADBEEF.
//  SB 0x80 @0x13 -> ram_be=1000, wdata=0x80808080. LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080.
//  LH @0x11 -> no ram strobe, bus_err pulse in DONE, ddata_r=0. Access @0x8000 -> bus_err.
//  RAM_WAIT=3: LW -> stall exactly 6 cycles, data correct, ram_rden one cycle only.
//  IO read @IO_BASE+4, io_ready after 5 cycles with 0x1234 -> io_addr=4, io_rd held 5 cycles, ddata_r=0x1234.
//  IO never ready -> strobe drops after 15 cycles, bus_err pulse; RESET_N low mid-WAIT -> all outputs 0 at once.

Source files
------------

// File: rtl/dmem_bus_ctrl.sv
// Data-side bus controller: decodes core load/store requests onto RAM or an IO window,
// stalls the core through the multi-cycle access and returns lane-extracted, extended load data.
module dmem_bus_ctrl #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          RAM_WAIT   = 0,
  parameter logic [31:0] IO_BASE    = 32'h0001_0000,
  parameter int          IO_SPAN    = 256,
  parameter int          IO_TIMEOUT = 15
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [31:0]                  daddr,
  input  logic [31:0]                  ddata_w,
  input  logic                         MemRead,
  input  logic                         MemWrite,
  input  logic [1:0]                   size,
  input  logic                         unsigned_n,
  output logic [31:0]                  ddata_r,
  output logic                         stall,
  output logic                         bus_err,
  output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
  output logic [31:0]                  ram_wdata,
  output logic [3:0]                   ram_be,
  output logic                         ram_wren,
  output logic                         ram_rden,
  input  logic [31:0]                  ram_rdata,
  output logic [$clog2(IO_SPAN)-1:0]   io_addr,
  output logic [31:0]                  io_wdata,
  output logic [3:0]                   io_be,
  output logic                         io_wr,
  output logic                         io_rd,
  input  logic                         io_ready,
  input  logic [31:0]                  io_rdata
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          IO_AW     = $clog2(IO_SPAN);
  localparam int          CNT_W     = 16;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [31:0] IO_MASK   = ~32'(IO_SPAN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_IO_REQ,
    S_DONE
  } state_t;

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] lane,
                                              input logic [1:0] sz, input logic sext);
    logic [31:0] sh;
    sh = raw >> {lane, 3'b000};
    case (sz)
      2'b00:   load_extend = {{24{sext & sh[7]}}, sh[7:0]};
      2'b01:   load_extend = {{16{sext & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  state_t              r_state;
  logic [RAM_AW-1:0]   r_ram_addr;
  logic [IO_AW-1:0]    r_io_addr;
  logic [1:0]          r_lane;
  logic [1:0]          r_size;
  logic                r_sext;
  logic                r_is_read;
  logic                r_first;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic [31:0]         r_ddata_r;
  logic                r_bus_err;
  logic                r_ram_rden;
  logic                r_ram_wren;
  logic                r_io_rd;
  logic                r_io_wr;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_req;
  logic                w_misalign;
  logic                w_ram_hit;
  logic                w_io_hit;
  logic                w_err;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_ram_word;

  assign w_req      = MemRead | MemWrite;
  assign w_misalign = ((size == 2'b01) && daddr[0]) || ((size == 2'b10) && (daddr[1:0] != 2'b00));
  assign w_ram_hit  = daddr < RAM_BYTES;
  assign w_io_hit   = (daddr & IO_MASK) == IO_BASE;
  assign w_err      = (size == 2'b11) || w_misalign || (MemRead && MemWrite) || !(w_ram_hit || w_io_hit);
  // With zero wait states the capture cycle is also the last one, so bypass the buffer.
  assign w_ram_word = r_first ? ram_rdata : r_rdata;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_be    = 4'h0;
    w_wdata = ddata_w;
    case (size)
      2'b00: begin
        w_be    = 4'b0001 << daddr[1:0];
        w_wdata = {4{ddata_w[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << daddr[1:0];
        w_wdata = {2{ddata_w[15:0]}};
      end
      2'b10:   w_be = 4'hF;
      default: w_be = 4'h0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_ram_addr <= '0;
      r_io_addr  <= '0;
      r_lane     <= 2'b00;
      r_size     <= 2'b00;
      r_sext     <= 1'b0;
      r_is_read  <= 1'b0;
      r_first    <= 1'b0;
      r_be       <= 4'h0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_ddata_r  <= '0;
      r_bus_err  <= 1'b0;
      r_ram_rden <= 1'b0;
      r_ram_wren <= 1'b0;
      r_io_rd    <= 1'b0;
      r_io_wr    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_ram_addr <= daddr[RAM_AW+1:2];
            r_io_addr  <= daddr[IO_AW-1:0];
            r_lane     <= daddr[1:0];
            r_size     <= size;
            r_sext     <= unsigned_n;
            r_is_read  <= MemRead;
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            r_cnt      <= '0;
            if (w_err) begin
              r_bus_err <= 1'b1;
              r_ddata_r <= '0;
              r_state   <= S_DONE;
            end else if (w_ram_hit) begin
              r_ram_rden <= MemRead;
              r_ram_wren <= MemWrite;
              r_state    <= S_ACCESS;
            end else begin
              r_io_rd <= MemRead;
              r_io_wr <= MemWrite;
              r_state <= S_IO_REQ;
            end
          end
        end
        S_ACCESS: begin
          r_ram_rden <= 1'b0;
          r_ram_wren <= 1'b0;
          r_cnt      <= CNT_W'(RAM_WAIT);
          r_first    <= 1'b1;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          r_first <= 1'b0;
          if (r_first) r_rdata <= ram_rdata;
          if (r_cnt == '0) begin
            if (r_is_read) r_ddata_r <= load_extend(w_ram_word, r_lane, r_size, r_sext);
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_IO_REQ: begin
          if (io_ready) begin
            r_io_rd <= 1'b0;
            r_io_wr <= 1'b0;
            if (r_is_read) r_ddata_r <= load_extend(io_rdata, r_lane, r_size, r_sext);
            r_state <= S_DONE;
          end else if (r_cnt == CNT_W'(IO_TIMEOUT - 1)) begin
            r_io_rd   <= 1'b0;
            r_io_wr   <= 1'b0;
            r_bus_err <= 1'b1;
            r_ddata_r <= '0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // The request still visible here belongs to the op completing now.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall     = w_req & (r_state != S_DONE);
  assign ddata_r   = r_ddata_r;
  assign bus_err   = r_bus_err;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_wdata;
  assign ram_be    = r_be;
  assign ram_wren  = r_ram_wren;
  assign ram_rden  = r_ram_rden;
  assign io_addr   = r_io_addr;
  assign io_wdata  = r_wdata;
  assign io_be     = r_be;
  assign io_wr     = r_io_wr;
  assign io_rd     = r_io_rd;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: one instance with zero RAM wait states (plus IO traffic)
// and one with three wait states, each backed by a small byte-enable RAM model.
module tb_dmem_bus_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET_N;
  logic        sel3;
  logic [31:0] daddr, ddata_w;
  logic        rd, wr;
  logic [1:0]  size;
  logic        unsigned_n;
  logic        io_ready;
  logic [31:0] io_rdata;

  logic [31:0] d0_ddata_r, d0_ram_wdata, d0_ram_rdata, d0_io_wdata;
  logic        d0_stall, d0_bus_err, d0_wren, d0_rden, d0_io_wr, d0_io_rd;
  logic [9:0]  d0_ram_addr;
  logic [3:0]  d0_ram_be, d0_io_be;
  logic [7:0]  d0_io_addr;

  logic [31:0] d3_ddata_r, d3_ram_wdata, d3_ram_rdata, d3_io_wdata;
  logic        d3_stall, d3_bus_err, d3_wren, d3_rden, d3_io_wr, d3_io_rd;
  logic [9:0]  d3_ram_addr;
  logic [3:0]  d3_ram_be, d3_io_be;
  logic [7:0]  d3_io_addr;

  dmem_bus_ctrl #(.RAM_WAIT(0)) u_dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .ddata_w(ddata_w),
    .MemRead(rd & ~sel3), .MemWrite(wr & ~sel3), .size(size), .unsigned_n(unsigned_n),
    .ddata_r(d0_ddata_r), .stall(d0_stall), .bus_err(d0_bus_err),
    .ram_addr(d0_ram_addr), .ram_wdata(d0_ram_wdata), .ram_be(d0_ram_be),
    .ram_wren(d0_wren), .ram_rden(d0_rden), .ram_rdata(d0_ram_rdata),
    .io_addr(d0_io_addr), .io_wdata(d0_io_wdata), .io_be(d0_io_be),
    .io_wr(d0_io_wr), .io_rd(d0_io_rd), .io_ready(io_ready), .io_rdata(io_rdata)
  );

  dmem_bus_ctrl #(.RAM_WAIT(3)) u_dut3 (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .ddata_w(ddata_w),
    .MemRead(rd & sel3), .MemWrite(wr & sel3), .size(size), .unsigned_n(unsigned_n),
    .ddata_r(d3_ddata_r), .stall(d3_stall), .bus_err(d3_bus_err),
    .ram_addr(d3_ram_addr), .ram_wdata(d3_ram_wdata), .ram_be(d3_ram_be),
    .ram_wren(d3_wren), .ram_rden(d3_rden), .ram_rdata(d3_ram_rdata),
    .io_addr(d3_io_addr), .io_wdata(d3_io_wdata), .io_be(d3_io_be),
    .io_wr(d3_io_wr), .io_rd(d3_io_rd), .io_ready(1'b0), .io_rdata(32'h0)
  );

  logic [31:0] mem0 [1024];
  logic [31:0] mem3 [1024];

  always @(posedge CLK) begin
    if (d0_wren)
      for (int b = 0; b < 4; b++)
        if (d0_ram_be[b]) mem0[d0_ram_addr][8*b +: 8] <= d0_ram_wdata[8*b +: 8];
    if (d0_rden) d0_ram_rdata <= mem0[d0_ram_addr];
  end

  always @(posedge CLK) begin
    if (d3_wren)
      for (int b = 0; b < 4; b++)
        if (d3_ram_be[b]) mem3[d3_ram_addr][8*b +: 8] <= d3_ram_wdata[8*b +: 8];
    if (d3_rden) d3_ram_rdata <= mem3[d3_ram_addr];
  end

  logic        o_stall, o_bus_err, o_rden, o_wren;
  logic [31:0] o_ddata_r, o_ram_wdata;
  logic [3:0]  o_ram_be;
  logic [9:0]  o_ram_addr;
  assign o_stall     = sel3 ? d3_stall     : d0_stall;
  assign o_bus_err   = sel3 ? d3_bus_err   : d0_bus_err;
  assign o_rden      = sel3 ? d3_rden      : d0_rden;
  assign o_wren      = sel3 ? d3_wren      : d0_wren;
  assign o_ddata_r   = sel3 ? d3_ddata_r   : d0_ddata_r;
  assign o_ram_wdata = sel3 ? d3_ram_wdata : d0_ram_wdata;
  assign o_ram_be    = sel3 ? d3_ram_be    : d0_ram_be;
  assign o_ram_addr  = sel3 ? d3_ram_addr  : d0_ram_addr;

  int checks = 0;
  int errors = 0;

  int          r_stalls, r_rden, r_wren, r_iord, r_iowr;
  logic [31:0] r_data, r_wdata_seen;
  logic        r_err;
  logic [3:0]  r_be_seen;
  logic [9:0]  r_addr_seen;
  logic [7:0]  r_ioaddr_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one request to completion starting at posedge+1 in IDLE; io_delay=0 means IO never ready.
  task automatic op(input logic use3, input logic rd_i, input logic wr_i, input logic [31:0] a,
                    input logic [31:0] d, input logic [1:0] sz, input logic sx,
                    input int io_delay, input logic [31:0] io_d);
    int n;
    int io_cycles;
    sel3 = use3; daddr = a; ddata_w = d; size = sz; unsigned_n = sx; rd = rd_i; wr = wr_i;
    r_stalls = 0; r_rden = 0; r_wren = 0; r_iord = 0; r_iowr = 0;
    r_data = 'x; r_err = 1'bx; r_be_seen = 'x; r_wdata_seen = 'x; r_addr_seen = 'x; r_ioaddr_seen = 'x;
    io_cycles = 0;
    n = 0;
    forever begin
      @(negedge CLK);
      io_ready = 1'b0;
      if (o_rden) begin r_rden++; r_addr_seen = o_ram_addr; end
      if (o_wren) begin
        r_wren++; r_addr_seen = o_ram_addr; r_be_seen = o_ram_be; r_wdata_seen = o_ram_wdata;
      end
      if (d0_io_rd | d0_io_wr) begin
        if (d0_io_rd) r_iord++;
        if (d0_io_wr) r_iowr++;
        io_cycles++;
        r_ioaddr_seen = d0_io_addr; r_be_seen = d0_io_be; r_wdata_seen = d0_io_wdata;
        if (io_cycles == io_delay) begin io_ready = 1'b1; io_rdata = io_d; end
      end
      if (!o_stall) begin r_data = o_ddata_r; r_err = o_bus_err; break; end
      r_stalls++;
      n++;
      if (n >= 100) begin
        checks++; errors++;
        $error("FAIL op_bound: stall still high after %0d cycles, required to drop", n);
        break;
      end
    end
    @(posedge CLK); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; sel3 = 1'b0; daddr = '0; ddata_w = '0; rd = 1'b0; wr = 1'b0;
    size = 2'b10; unsigned_n = 1'b0; io_ready = 1'b0; io_rdata = '0;

    // Reset state: stall follows the request combinationally, everything else is zero.
    #1 rd = 1'b1;
    #1 check("rst_stall_req", d0_stall, 1);
    rd = 1'b0;
    #1 check("rst_stall_idle", d0_stall, 0);
    check("rst_outputs", {d0_bus_err, d0_wren, d0_rden, d0_io_wr, d0_io_rd, d0_ram_be, d0_io_addr}, 0);
    check("rst_ddata_r", d0_ddata_r, 0);
    @(posedge CLK); #1 RESET_N = 1'b1;
    @(posedge CLK); #1;

    // SW 0xDEADBEEF @0x10
    op(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0, 0, 0);
    check("sw_stall", r_stalls, 3);
    check("sw_wren", r_wren, 1);
    check("sw_rden", r_rden, 0);
    check("sw_be", r_be_seen, 4'hF);
    check("sw_wdata", r_wdata_seen, 32'hDEAD_BEEF);
    check("sw_addr", r_addr_seen, 10'd4);
    check("sw_err", r_err, 0);

    // LW @0x10
    op(0, 1, 0, 32'h10, 0, 2'b10, 0, 0, 0);
    check("lw_stall", r_stalls, 3);
    check("lw_rden", r_rden, 1);
    check("lw_data", r_data, 32'hDEAD_BEEF);
    check("lw_err", r_err, 0);

    // SB 0x80 @0x13: only the low byte of the store data is used
    op(0, 0, 1, 32'h13, 32'h1234_5680, 2'b00, 0, 0, 0);
    check("sb_be", r_be_seen, 4'b1000);
    check("sb_wdata", r_wdata_seen, 32'h8080_8080);

    // Word at 0x10 is now 0x80ADBEEF
    op(0, 1, 0, 32'h13, 0, 2'b00, 1, 0, 0);
    check("lb_sext", r_data, 32'hFFFF_FF80);
    op(0, 1, 0, 32'h13, 0, 2'b00, 0, 0, 0);
    check("lbu", r_data, 32'h0000_0080);
    op(0, 1, 0, 32'h11, 0, 2'b00, 1, 0, 0);
    check("lb_lane1", r_data, 32'hFFFF_FFBE);
    op(0, 1, 0, 32'h12, 0, 2'b01, 1, 0, 0);
    check("lh_hi_sext", r_data, 32'hFFFF_80AD);
    op(0, 1, 0, 32'h10, 0, 2'b01, 0, 0, 0);
    check("lhu_lo", r_data, 32'h0000_BEEF);

    // SH @0x16 then LHU back
    op(0, 0, 1, 32'h16, 32'h5A5A_1234, 2'b01, 0, 0, 0);
    check("sh_be", r_be_seen, 4'b1100);
    check("sh_wdata", r_wdata_seen, 32'h1234_1234);
    op(0, 1, 0, 32'h16, 0, 2'b01, 0, 0, 0);
    check("lhu_sh", r_data, 32'h0000_1234);

    // Misaligned half: no strobe, error pulse, data 0, pulse lasts one cycle
    op(0, 1, 0, 32'h11, 0, 2'b01, 1, 0, 0);
    check("mis_stall", r_stalls, 1);
    check("mis_strobes", r_rden + r_wren, 0);
    check("mis_err", r_err, 1);
    check("mis_data", r_data, 0);
    @(negedge CLK);
    check("mis_err_pulse", d0_bus_err, 0);
    @(posedge CLK); #1;

    // Unmapped, illegal size, read+write together
    op(0, 1, 0, 32'h8000, 0, 2'b10, 0, 0, 0);
    check("unmapped_err", r_err, 1);
    check("unmapped_rden", r_rden, 0);
    op(0, 1, 0, 32'h10, 0, 2'b11, 0, 0, 0);
    check("size11_err", r_err, 1);
    op(0, 1, 1, 32'h10, 32'h1, 2'b10, 0, 0, 0);
    check("rdwr_err", r_err, 1);
    check("rdwr_strobes", r_rden + r_wren, 0);

    // IO read @IO_BASE+4, ready in the 5th strobe cycle
    op(0, 1, 0, 32'h0001_0004, 0, 2'b10, 0, 5, 32'h0000_1234);
    check("io_rd_cycles", r_iord, 5);
    check("io_addr", r_ioaddr_seen, 8'd4);
    check("io_rd_data", r_data, 32'h0000_1234);
    check("io_rd_stall", r_stalls, 6);
    check("io_rd_err", r_err, 0);

    // IO half write @IO_BASE+2, ready at once
    op(0, 0, 1, 32'h0001_0002, 32'h0000_ABCD, 2'b01, 0, 1, 0);
    check("io_wr_cycles", r_iowr, 1);
    check("io_wr_be", r_be_seen, 4'b1100);
    check("io_wr_wdata", r_wdata_seen, 32'hABCD_ABCD);

    // IO never ready: timeout after 15 strobe cycles
    op(0, 1, 0, 32'h0001_0010, 0, 2'b10, 0, 0, 0);
    check("io_to_cycles", r_iord, 15);
    check("io_to_stall", r_stalls, 16);
    check("io_to_err", r_err, 1);
    check("io_to_data", r_data, 0);

    // Three RAM wait states
    op(1, 0, 1, 32'h20, 32'hCAFE_F00D, 2'b10, 0, 0, 0);
    check("w3_sw_stall", r_stalls, 6);
    check("w3_sw_wren", r_wren, 1);
    op(1, 1, 0, 32'h20, 0, 2'b10, 0, 0, 0);
    check("w3_lw_stall", r_stalls, 6);
    check("w3_lw_rden", r_rden, 1);
    check("w3_lw_data", r_data, 32'hCAFE_F00D);

    // Reset while in WAIT: outputs clear at once, no completion
    sel3 = 1'b1; daddr = 32'h20; size = 2'b10; unsigned_n = 1'b0; rd = 1'b1;
    repeat (3) @(negedge CLK);
    check("w3_mid_stall", d3_stall, 1);
    #2 RESET_N = 1'b0;
    #1;
    check("rst_mid_ddata", d3_ddata_r, 0);
    check("rst_mid_strobes", {d3_bus_err, d3_wren, d3_rden, d3_io_wr, d3_io_rd}, 0);
    check("rst_mid_bus", {d3_ram_be, d3_ram_addr, d3_io_addr}, 0);
    check("rst_mid_wdata", d3_ram_wdata, 0);
    check("rst_mid_stall", d3_stall, 1);
    rd = 1'b0;
    @(posedge CLK); #1 RESET_N = 1'b1;
    @(negedge CLK);
    check("rst_no_complete", {d3_bus_err, d3_ddata_r}, 0);
    @(posedge CLK); #1;
    op(1, 1, 0, 32'h20, 0, 2'b10, 0, 0, 0);
    check("post_rst_lw", r_data, 32'hCAFE_F00D);
    check("post_rst_stall", r_stalls, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
